// File: rtl/fp_pkg.sv
// Shared definitions for the FP special-operand resolver: operand class codes
// and a builder for the canonical quiet NaN.
package fp_pkg;

    // Operand class codes carried on out_type_a/out_type_b.
    typedef enum logic [2:0] {
        ZERO      = 3'b000,
        INF       = 3'b001,
        SUBNORMAL = 3'b010,
        NORMAL    = 3'b011,
        NAN       = 3'b100
    } fp_class_e;

    // Widest word the qNaN builder can produce; callers size-cast down to W.
    localparam int unsigned FP_MAX_W = 64;

    // Canonical quiet NaN {sign, all-ones exponent, 1'b1, zeros} for any format
    // whose total width fits in FP_MAX_W bits.
    function automatic logic [FP_MAX_W-1:0] canonical_qnan(
        input logic        sign,
        input int unsigned exp_w,
        input int unsigned man_w
    );
        logic [FP_MAX_W-1:0] word;
        word = ((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1)) << man_w;
        word[man_w-1]       = 1'b1;
        word[exp_w + man_w] = sign;
        return word;
    endfunction

endpackage

// File: rtl/fp_special_cases_pipe_if.sv
// Handshake bundle for fp_special_cases_pipe: operand input side and result
// output side. The master modport belongs to the producer/consumer around the
// block, the slave modport to the block itself.
// Optional flag outputs are present when FP_SPECIAL_FLAGS_EN is defined.
interface fp_special_cases_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    import fp_pkg::*;

    localparam int W = 1 + EXP_W + MAN_W;

    // Input side
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;

    // Output side
    logic         out_valid;
    logic         out_ready;
    logic         out_special;
    logic [W-1:0] out_result;
    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    fp_class_e    out_type_a;
    fp_class_e    out_type_b;

`ifdef FP_SPECIAL_FLAGS_EN
    logic         out_flag_invalid;
    logic         out_flag_nan_in;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_special, out_result, out_a, out_b,
               out_type_a, out_type_b, out_flag_invalid, out_flag_nan_in
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_special, out_result, out_a, out_b,
               out_type_a, out_type_b, out_flag_invalid, out_flag_nan_in
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_special, out_result, out_a, out_b,
               out_type_a, out_type_b
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_special, out_result, out_a, out_b,
               out_type_a, out_type_b
    );
`endif

endinterface

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand classifier. Takes the exponent and mantissa
// fields only; the sign never affects the class.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W-1:0] exp_i,
    input  logic [MAN_W-1:0] man_i,
    output fp_class_e        cls_o
);

    logic exp_zero;
    logic exp_ones;
    logic man_zero;

    assign exp_zero = ~|exp_i;
    assign exp_ones = &exp_i;
    assign man_zero = ~|man_i;

    // Map exponent/mantissa field patterns onto the class code.
    always_comb begin
        cls_o = NORMAL;
        if (exp_zero) begin
            cls_o = man_zero ? ZERO : SUBNORMAL;
        end else if (exp_ones) begin
            cls_o = man_zero ? INF : NAN;
        end
    end

endmodule

// File: rtl/fp_special_cases_pipe.sv
// Two-stage valid/ready special-operand resolver for the FP add/sub datapath.
// S1 registers the operands (B sign already flipped for subtract) and their
// classes; S2 registers the special-case resolution, or flags the pair for
// the normal adder path when no special rule applies.
// Optional feature macro: FP_SPECIAL_FLAGS_EN adds out_flag_invalid and
// out_flag_nan_in; the resolved result is identical either way.
module fp_special_cases_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic                    clk,
    input logic                    rst,
    fp_special_cases_pipe_if.slave bus
);

    localparam int W = 1 + EXP_W + MAN_W;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s2_free;   // S2 can take a new entry this cycle
    logic in_ready;
    logic in_fire;
    logic s1_move;   // S1 entry advances into S2 this cycle

    // ------------------------------------------------------------------
    // Stage 1 state
    // ------------------------------------------------------------------
    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] s1_a_q,     s1_a_d;
    logic [W-1:0] s1_b_q,     s1_b_d;
    fp_class_e    s1_type_a_q, s1_type_a_d;
    fp_class_e    s1_type_b_q, s1_type_b_d;

    // ------------------------------------------------------------------
    // Stage 2 (output) state
    // ------------------------------------------------------------------
    logic         out_valid_q,   out_valid_d;
    logic         out_special_q, out_special_d;
    logic [W-1:0] out_result_q,  out_result_d;
    logic [W-1:0] out_a_q,       out_a_d;
    logic [W-1:0] out_b_q,       out_b_d;
    fp_class_e    out_type_a_q,  out_type_a_d;
    fp_class_e    out_type_b_q,  out_type_b_d;

    // ------------------------------------------------------------------
    // Input conditioning and classification
    // ------------------------------------------------------------------
    logic [W-1:0] in_b_eff;
    fp_class_e    in_type_a;
    fp_class_e    in_type_b;

    assign in_b_eff = {bus.in_b[W-1] ^ bus.in_sub, bus.in_b[W-2:0]};

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classify_a (
        .exp_i (bus.in_a[W-2:MAN_W]),
        .man_i (bus.in_a[MAN_W-1:0]),
        .cls_o (in_type_a)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classify_b (
        .exp_i (in_b_eff[W-2:MAN_W]),
        .man_i (in_b_eff[MAN_W-1:0]),
        .cls_o (in_type_b)
    );

    // Pipeline handshake: a stage moves when it is empty or its consumer takes.
    always_comb begin
        s2_free  = !out_valid_q || bus.out_ready;
        in_ready = !s1_valid_q || s2_free;
        in_fire  = bus.in_valid && in_ready;
        s1_move  = s1_valid_q && s2_free;
    end

    // S1 next state: capture operands and classes on an accepted input.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_type_a_d = s1_type_a_q;
        s1_type_b_d = s1_type_b_q;
        if (in_ready) begin
            s1_valid_d = bus.in_valid;
        end
        if (in_fire) begin
            s1_a_d      = bus.in_a;
            s1_b_d      = in_b_eff;
            s1_type_a_d = in_type_a;
            s1_type_b_d = in_type_b;
        end
    end

    // ------------------------------------------------------------------
    // Special-case resolution on the S1 entry
    // ------------------------------------------------------------------
    logic         sign_a, sign_b;
    logic         zero_a, zero_b;
    logic         inf_a,  inf_b;
    logic         nan_a,  nan_b;
    logic [W-1:0] quiet_a, quiet_b;
    logic         res_special;
    logic [W-1:0] res_result;

    // Decode the registered classes and build the quieted NaN candidates.
    always_comb begin
        sign_a  = s1_a_q[W-1];
        sign_b  = s1_b_q[W-1];
        zero_a  = (s1_type_a_q == ZERO);
        zero_b  = (s1_type_b_q == ZERO);
        inf_a   = (s1_type_a_q == INF);
        inf_b   = (s1_type_b_q == INF);
        nan_a   = (s1_type_a_q == NAN);
        nan_b   = (s1_type_b_q == NAN);
        quiet_a = s1_a_q;
        quiet_a[MAN_W-1] = 1'b1;
        quiet_b = s1_b_q;
        quiet_b[MAN_W-1] = 1'b1;
    end

    // Priority rules, first match wins; fall through means "send to adder".
    always_comb begin
        res_special = 1'b1;
        res_result  = '0;
        if (nan_a && nan_b) begin
            // Larger payload wins; a tie keeps A.
            res_result = (s1_b_q[MAN_W-2:0] > s1_a_q[MAN_W-2:0]) ? quiet_b : quiet_a;
        end else if (zero_a && zero_b) begin
            res_result = {sign_a & sign_b, {(W-1){1'b0}}};
        end else if (zero_a || nan_b) begin
            res_result = nan_b ? quiet_b : s1_b_q;
        end else if (zero_b || nan_a) begin
            res_result = nan_a ? quiet_a : s1_a_q;
        end else if (inf_a) begin
            // inf - inf is invalid; same-sign infinities and finite B return A as-is.
            if (inf_b && (sign_a != sign_b)) begin
                res_result = W'(canonical_qnan(sign_a, EXP_W, MAN_W));
            end else begin
                res_result = s1_a_q;
            end
        end else if (inf_b) begin
            res_result = s1_b_q;
        end else begin
            res_special = 1'b0;
        end
    end

    // S2 next state: load the resolution when S1 advances, hold while stalled.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_special_d = out_special_q;
        out_result_d  = out_result_q;
        out_a_d       = out_a_q;
        out_b_d       = out_b_q;
        out_type_a_d  = out_type_a_q;
        out_type_b_d  = out_type_b_q;
        if (s2_free) begin
            out_valid_d = s1_valid_q;
        end
        if (s1_move) begin
            out_special_d = res_special;
            out_result_d  = res_result;
            out_a_d       = s1_a_q;
            out_b_d       = s1_b_q;
            out_type_a_d  = s1_type_a_q;
            out_type_b_d  = s1_type_b_q;
        end
    end

    // Pipeline registers with synchronous reset; reset drops all in-flight pairs.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are reset too, because their reset values are visible on the outputs.
            s1_valid_q    <= 1'b0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_type_a_q   <= ZERO;
            s1_type_b_q   <= ZERO;
            out_valid_q   <= 1'b0;
            out_special_q <= 1'b0;
            out_result_q  <= '0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_type_a_q  <= ZERO;
            out_type_b_q  <= ZERO;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s1_valid_q    <= s1_valid_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            s1_type_a_q   <= s1_type_a_d;
            s1_type_b_q   <= s1_type_b_d;
            out_valid_q   <= out_valid_d;
            out_special_q <= out_special_d;
            out_result_q  <= out_result_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            out_type_a_q  <= out_type_a_d;
            out_type_b_q  <= out_type_b_d;
        end
    end

`ifdef FP_SPECIAL_FLAGS_EN
    // ------------------------------------------------------------------
    // Exception flags, travelling alongside the S2 result
    // ------------------------------------------------------------------
    logic flag_invalid_q, flag_invalid_d;
    logic flag_nan_in_q,  flag_nan_in_d;
    logic snan_a, snan_b;
    logic inf_clash;

    // Invalid on inf-inf or any signalling NaN input; nan_in on any NaN input.
    always_comb begin
        snan_a         = nan_a && !s1_a_q[MAN_W-1];
        snan_b         = nan_b && !s1_b_q[MAN_W-1];
        inf_clash      = inf_a && inf_b && (sign_a != sign_b);
        flag_invalid_d = flag_invalid_q;
        flag_nan_in_d  = flag_nan_in_q;
        if (s1_move) begin
            flag_invalid_d = inf_clash || snan_a || snan_b;
            flag_nan_in_d  = nan_a || nan_b;
        end
    end

    // Flag registers share the S2 reset and advance rules.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_invalid_q <= 1'b0;
            flag_nan_in_q  <= 1'b0;
        end else begin
            flag_invalid_q <= flag_invalid_d;
            flag_nan_in_q  <= flag_nan_in_d;
        end
    end

    assign bus.out_flag_invalid = flag_invalid_q;
    assign bus.out_flag_nan_in  = flag_nan_in_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_special = out_special_q;
    assign bus.out_result  = out_result_q;
    assign bus.out_a       = out_a_q;
    assign bus.out_b       = out_b_q;
    assign bus.out_type_a  = out_type_a_q;
    assign bus.out_type_b  = out_type_b_q;

endmodule
